// File: rtl/mod_counter_pkg.sv
// Shared types and elaboration helpers for the modulo up/down counter.
// Parameter legality and prescaler sizing live here so top and sub-module agree.
package mod_counter_pkg;

   typedef enum logic {MODE_WRAP, MODE_SAT} mode_e;

   // A 1-bit prescaler register is kept even when PRESCALE==1 to avoid zero-width vectors.
   function automatic int presc_width(input int p);
      if (p <= 1) return 1;
      return $clog2(p);
   endfunction

   function automatic bit params_legal(input int w, input int m, input int p);
      return (m >= 2) && (m <= (1 << w)) && (p >= 1);
   endfunction

endpackage

// File: rtl/mod_counter_ps_step_prescaler.sv
// Divides enabled clocks by PRESCALE; step is high on the last enabled clock of each period.
// restart (clr/load in the top) returns the phase to 0.
module step_prescaler
   import mod_counter_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic restart,
   output logic step
);

   localparam int            PW   = presc_width(PRESCALE);
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] r_cnt;
   logic          w_last;

   assign w_last = (r_cnt == LAST);
   assign step   = en & w_last;

   always_ff @(posedge clk) begin
      if (!reset || restart) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mod_counter_ps.sv
// Modulo up/down counter with prescaled steps, wrap/saturate ends,
// a registered terminal-count pulse and a sticky overflow flag.
module mod_counter_ps
   import mod_counter_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MODULUS  = 10,
   parameter int PRESCALE = 1,
   parameter int SATURATE = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr,
   input  logic             ovf_clr,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             ovf
);

   if (!params_legal(WIDTH, MODULUS, PRESCALE)) begin : g_illegal
      $error("mod_counter_ps: illegal MODULUS=%0d or PRESCALE=%0d for WIDTH=%0d",
             MODULUS, PRESCALE, WIDTH);
   end

   localparam mode_e          MODE    = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;
   // One extra bit so MODULUS == 2**WIDTH is representable in compares.
   localparam logic [WIDTH:0] MOD_EXT = (WIDTH + 1)'(MODULUS);
   localparam logic [WIDTH:0] MAX_EXT = (WIDTH + 1)'(MODULUS - 1);

   logic [WIDTH-1:0] r_count;
   logic             r_tc;
   logic             r_ovf;

   logic             w_step;
   logic             w_bnd;
   logic [WIDTH:0]   w_cnt_ext;
   logic [WIDTH:0]   w_lv_ext;
   logic [WIDTH:0]   w_load_ext;
   logic [WIDTH:0]   w_next;

   step_prescaler #(.PRESCALE(PRESCALE)) u_presc (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .restart (clr | load),
      .step    (w_step)
   );

   assign w_cnt_ext  = {1'b0, r_count};
   assign w_lv_ext   = {1'b0, load_val};
   assign w_load_ext = (w_lv_ext >= MOD_EXT) ? MAX_EXT : w_lv_ext;

   always_comb begin
      w_next = w_cnt_ext;
      w_bnd  = 1'b0;
      if (w_step) begin
         if (up_dn) begin
            if (w_cnt_ext == MAX_EXT) begin
               w_bnd  = 1'b1;
               w_next = (MODE == MODE_SAT) ? MAX_EXT : '0;
            end else begin
               w_next = w_cnt_ext + 1'b1;
            end
         end else begin
            if (w_cnt_ext == '0) begin
               w_bnd  = 1'b1;
               w_next = (MODE == MODE_SAT) ? '0 : MAX_EXT;
            end else begin
               w_next = w_cnt_ext - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_count <= '0;
         r_tc    <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         if (clr) begin
            r_count <= '0;
            r_tc    <= 1'b0;
         end else if (load) begin
            r_count <= w_load_ext[WIDTH-1:0];
            r_tc    <= 1'b0;
         end else begin
            r_count <= w_next[WIDTH-1:0];
            r_tc    <= w_bnd;
         end
         // A boundary step on the same edge beats ovf_clr.
         if (!clr && !load && w_bnd) r_ovf <= 1'b1;
         else if (ovf_clr)           r_ovf <= 1'b0;
      end
   end

   assign count = r_count;
   assign tc    = r_tc;
   assign ovf   = r_ovf;

endmodule
